// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, parity, 1-2 stop bits, 2-of-3 vote); define UART_RX_BREAK_DETECT_EN to enable break detection
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT  = 87,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int MAJORITY_VOTE = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy,
  output logic                 o_Break
);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic HAS_PAR = PARITY_MODE != 0;
  localparam logic ODD = PARITY_MODE == 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0] hist;
  logic sync1, rx_s, par_bit, ferr, bit_end, bit_val, par_err, frame_err, is_break;
  always_comb begin
    bit_end = cnt == LAST;
    bit_val = MAJORITY_VOTE != 0 ? (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s) : rx_s;
    par_err = HAS_PAR & (par_bit ^ (^shreg) ^ ODD);
    frame_err = ferr | ~bit_val;
`ifdef UART_RX_BREAK_DETECT_EN
    is_break = ~|shreg & ~(HAS_PAR & par_bit) & ~bit_val & ((STOP_BITS == 1) | ferr);
`else
    is_break = 1'b0;
`endif
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      hist <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      ferr <= 1'b0;
      o_Rx_DV <= 1'b0;
      o_Rx_Byte <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy <= 1'b0;
      o_Break <= 1'b0;
    end else begin
      sync1 <= i_Rx_Serial;
      rx_s <= sync1;
      hist <= {hist[0], rx_s};
      o_Rx_DV <= 1'b0;
      o_Break <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          o_Busy <= ~rx_s;
          state <= rx_s ? IDLE : START;
        end
        START: begin
          cnt <= cnt == HALF ? '0 : cnt + 16'd1;
          if (cnt == HALF) begin
            o_Busy <= ~rx_s;
            state <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          cnt <= bit_end ? '0 : cnt + 16'd1;
          if (bit_end) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            idx <= idx == LAST_DATA ? '0 : idx + 1'b1;
            ferr <= 1'b0;
            if (idx == LAST_DATA) state <= HAS_PAR ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt <= bit_end ? '0 : cnt + 16'd1;
          if (bit_end) begin
            par_bit <= bit_val;
            state <= STOP;
          end
        end
        STOP: begin
          cnt <= bit_end ? '0 : cnt + 16'd1;
          if (bit_end) begin
            idx <= idx == LAST_STOP ? '0 : idx + 1'b1;
            ferr <= frame_err;
            if (idx == LAST_STOP) begin
              o_Rx_DV <= ~is_break;
              o_Break <= is_break;
              state <= is_break ? WAIT_HIGH : CLEANUP;
              if (!is_break) begin
                o_Rx_Byte <= shreg;
                o_Parity_Err <= par_err;
                o_Frame_Err <= frame_err;
              end
            end
          end
        end
        CLEANUP, WAIT_HIGH: begin
          o_Busy <= ~rx_s;
          state <= rx_s ? IDLE : WAIT_HIGH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench driving three uart_rx_cfg configurations against a frame-level reference model
module tb_uart_rx_cfg;
  localparam int C0 = 87, C1 = 16, C2 = 10;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  typedef struct {
    int         s;
    logic [8:0] d;
    bit         pflip;
    logic [1:0] stops;
    logic [8:0] eb;
    logic       ep;
    logic       ef;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] dv, pe, fe, busy, brk;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [8:0] byte_c;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int n_dv[3], n_brk[3], dv_cyc[3], t_start[3];
  logic [8:0] l_byte[3], exp_last[3];
  logic l_pe[3], l_fe[3];
  uart_rx_cfg u_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Busy(busy[0]), .o_Break(brk[0])
  );
  uart_rx_cfg #(.CLKS_PER_BIT(C1), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .MAJORITY_VOTE(1)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Busy(busy[1]), .o_Break(brk[1])
  );
  uart_rx_cfg #(.CLKS_PER_BIT(C2), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1), .MAJORITY_VOTE(0)) u_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(byte_c),
    .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Busy(busy[2]), .o_Break(brk[2])
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [8:0] cur_byte(input int s);
    return s == 0 ? 9'(byte_a) : s == 1 ? 9'(byte_b) : byte_c;
  endfunction
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (dv[s]) begin
        n_dv[s]++;
        dv_cyc[s] = cyc;
        l_pe[s] = pe[s];
        l_fe[s] = fe[s];
        l_byte[s] = cur_byte(s);
      end
      if (brk[s]) n_brk[s]++;
    end
  end
  function automatic int cpb(input int s);
    return s == 0 ? C0 : s == 1 ? C1 : C2;
  endfunction
  function automatic int nbits(input int s);
    return s == 0 ? 8 : s == 1 ? 7 : 9;
  endfunction
  function automatic int pmode(input int s);
    return s == 0 ? 0 : s == 1 ? 2 : 1;
  endfunction
  function automatic int nstop(input int s);
    return s == 1 ? 2 : 1;
  endfunction
  function automatic logic par_of(input int s, input logic [8:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < nbits(s); i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ (pmode(s) == 1);
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input int s, input logic v, input int n);
    rx[s] = v;
    tick(n);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input int s, input logic [8:0] d, input bit pflip, input logic [1:0] stops, input int hold);
    int c;
    c = cpb(s);
    t_start[s] = cyc;
    drive(s, 1'b0, c);
    for (int i = 0; i < nbits(s); i++) drive(s, d[i], c);
    if (pmode(s) != 0) drive(s, par_of(s, d) ^ pflip, c);
    for (int i = 0; i < nstop(s); i++) drive(s, stops[i], c);
    if (hold > 0) drive(s, 1'b0, hold);
    drive(s, 1'b1, 2 * c);
  endtask
  task automatic model(input int s, input logic [8:0] d, input bit pflip, input logic [1:0] stops,
                       output logic [8:0] eb, output logic ep, output logic ef, output logic isb);
    logic [1:0] full;
    logic pbit;
    full = nstop(s) == 2 ? 2'b11 : 2'b01;
    eb = d & ((9'd1 << nbits(s)) - 9'd1);
    pbit = pmode(s) != 0 && (par_of(s, d) ^ pflip);
    ep = pmode(s) != 0 && pflip;
    ef = (stops & full) != full;
    isb = BRK_EN && eb == 9'd0 && !pbit && (stops & full) == 2'b00;
  endtask
  task automatic check_frame(input int s, input int dv0, input int brk0, input logic [8:0] eb,
                             input logic ep, input logic ef, input logic isb, input bit lat);
    int nb;
    nb = nbits(s) + (pmode(s) != 0 ? 1 : 0) + nstop(s);
    if (isb) begin
      chk("break_pulses", n_brk[s] - brk0, 1);
      chk("dv_during_break", n_dv[s] - dv0, 0);
      chk("byte_held_on_break", cur_byte(s), exp_last[s]);
    end else begin
      chk("dv_pulses", n_dv[s] - dv0, 1);
      chk("break_quiet", n_brk[s] - brk0, 0);
      chk("rx_byte", l_byte[s], eb);
      chk("parity_err", l_pe[s], ep);
      chk("frame_err", l_fe[s], ef);
      chk("byte_held", cur_byte(s), eb);
      if (lat) chk("dv_latency", dv_cyc[s] - t_start[s], 4 + (cpb(s) - 1) / 2 + nb * cpb(s));
      exp_last[s] = eb;
    end
  endtask
  initial begin
    vec_t tbl[10];
    int s, dv0, brk0;
    logic [8:0] d, eb;
    logic [1:0] st;
    logic pf, ep, ef, isb;
    tbl[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h035, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0};
    tbl[2] = '{1, 9'h035, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0};
    tbl[3] = '{1, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
    tbl[4] = '{1, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
    tbl[5] = '{2, 9'h1A5, 1'b0, 2'b11, 9'h1A5, 1'b0, 1'b0};
    tbl[6] = '{2, 9'h100, 1'b1, 2'b00, 9'h100, 1'b1, 1'b1};
    tbl[7] = '{0, 9'h080, 1'b0, 2'b00, 9'h080, 1'b0, 1'b1};
    tbl[8] = '{2, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b0};
    tbl[9] = '{1, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) exp_last[i] = 9'd0;
    tick(5);
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags", {dv[i], pe[i], fe[i], busy[i], brk[i]}, 0);
      chk("reset_byte", cur_byte(i), 0);
    end
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      dv0 = n_dv[tbl[i].s];
      brk0 = n_brk[tbl[i].s];
      send(tbl[i].s, tbl[i].d, tbl[i].pflip, tbl[i].stops, 0);
      check_frame(tbl[i].s, dv0, brk0, tbl[i].eb, tbl[i].ep, tbl[i].ef, 1'b0, 1'b1);
    end
    for (int k = 0; k < 36; k++) begin
      s = int'($urandom_range(0, 2));
      d = 9'($urandom);
      pf = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        d = 9'd0;
        st = 2'b00;
      end
      dv0 = n_dv[s];
      brk0 = n_brk[s];
      send(s, d, pf, st, 0);
      model(s, d, pf, st, eb, ep, ef, isb);
      check_frame(s, dv0, brk0, eb, ep, ef, isb, 1'b1);
    end
    dv0 = n_dv[0];
    brk0 = n_brk[0];
    t_start[0] = cyc;
    drive(0, 1'b0, (C0 - 1) / 2 + 4 * C0);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 9 * C0 - (C0 - 1) / 2 - 4 * C0 - 1);
    drive(0, 1'b1, 3 * C0);
    check_frame(0, dv0, brk0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    dv0 = n_dv[0];
    drive(0, 1'b0, 20);
    chk("busy_false_start", busy[0], 1);
    drive(0, 1'b1, 45);
    chk("busy_after_false_start", busy[0], 0);
    chk("dv_false_start", n_dv[0] - dv0, 0);
    dv0 = n_dv[0];
    brk0 = n_brk[0];
    send(0, 9'h05A, 1'b0, 2'b11, 0);
    check_frame(0, dv0, brk0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1);
    dv0 = n_dv[0];
    drive(0, 1'b0, C0);
    drive(0, 1'b1, 4 * C0 + C0 / 2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("reset_mid_frame_byte", cur_byte(0), 0);
    chk("reset_mid_frame_busy", busy[0], 0);
    for (int i = 0; i < 3; i++) exp_last[i] = 9'd0;
    drive(0, 1'b1, 8 * C0);
    chk("dv_after_abort", n_dv[0] - dv0, 0);
    dv0 = n_dv[0];
    brk0 = n_brk[0];
    send(0, 9'h012, 1'b0, 2'b11, 0);
    check_frame(0, dv0, brk0, 9'h012, 1'b0, 1'b0, 1'b0, 1'b1);
    dv0 = n_dv[1];
    brk0 = n_brk[1];
    send(1, 9'h03C, 1'b0, 2'b01, 500);
    check_frame(1, dv0, brk0, 9'h03C, 1'b0, 1'b1, 1'b0, 1'b1);
    dv0 = n_dv[1];
    brk0 = n_brk[1];
    send(1, 9'h02A, 1'b0, 2'b11, 0);
    check_frame(1, dv0, brk0, 9'h02A, 1'b0, 1'b0, 1'b0, 1'b1);
    dv0 = n_dv[0];
    brk0 = n_brk[0];
    t_start[0] = cyc;
    drive(0, 1'b0, 12 * C0);
    drive(0, 1'b1, 3 * C0);
    model(0, 9'h000, 1'b0, 2'b00, eb, ep, ef, isb);
    check_frame(0, dv0, brk0, eb, ep, ef, isb, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
